// File: rtl/sprite_blit_engine.sv
// Sprite blitter: walks a SPR_W x SPR_H palette ROM in raster order and writes opaque, on-screen pixels to the frame buffer.
// Latency: start -> first fb_we in 3 cycles; done pulses 3+SPR_W*SPR_H cycles after start (fb_ready held high).
// Backpressure: fb_we && !fb_ready freezes the whole pipeline; a skid register keeps the in-flight ROM pixel.
// Optional SPRITE_BLIT_MIRROR_EN adds a 'mirror' input that reads each ROM row right-to-left (horizontal flip).
module sprite_blit_engine #(
  parameter int SPR_W  = 40,
  parameter int SPR_H  = 60,
  parameter int PIX_W  = 5,
  parameter int ADDR_W = 19,
  parameter int FB_W   = 640,
  parameter int FB_H   = 480,
  parameter logic [PIX_W-1:0] TRANSPARENT = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
`ifdef SPRITE_BLIT_MIRROR_EN
  input  logic              mirror,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  output logic              fb_we,
  input  logic              fb_ready
);

  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  // Latched blit parameters
  logic [9:0]        r_x, r_y;
  logic              r_mirror;
  logic              w_mirror_in;

  // Address stage: coordinates of the address currently on rom_addr
  logic [ROW_W-1:0]  r_a_row;
  logic [COL_W-1:0]  r_a_col;
  logic [ADDR_W-1:0] r_rom_addr;

  // Data stage: coordinates of the pixel whose data is on rom_data (or in the skid)
  logic              r_d_vld;
  logic [ROW_W-1:0]  r_d_row;
  logic [COL_W-1:0]  r_d_col;
  logic              r_skid_vld;
  logic [PIX_W-1:0]  r_skid_pix;

  // Output stage
  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [PIX_W-1:0]  r_fb_data;
  logic              r_busy, r_done;

  // Control and next-value wires
  logic              w_adv, w_a_last, w_accept, w_issue, w_finish;
  logic [ROW_W-1:0]  w_row_nxt;
  logic [COL_W-1:0]  w_col_nxt, w_rom_col;
  logic              w_mir_nxt;
  logic [ADDR_W-1:0] w_rom_addr_nxt;
  logic [PIX_W-1:0]  w_d_pix;
  logic [10:0]       w_sx, w_sy;
  logic              w_keep;
  logic [ADDR_W-1:0] w_fb_addr;

`ifdef SPRITE_BLIT_MIRROR_EN
  assign w_mirror_in = mirror;
`else
  assign w_mirror_in = 1'b0;
`endif

  // A pending write that is not being taken stalls every stage
  assign w_adv    = !(r_fb_we && !fb_ready);
  assign w_a_last = (r_a_row == ROW_W'(SPR_H-1)) && (r_a_col == COL_W'(SPR_W-1));

  // Pixel leaving the data stage: skid copy wins if the ROM output moved on during a stall
  assign w_d_pix   = r_skid_vld ? r_skid_pix : rom_data;
  assign w_sx      = 11'(r_x) + 11'(r_d_col);
  assign w_sy      = 11'(r_y) + 11'(r_d_row);
  assign w_keep    = (w_d_pix != TRANSPARENT) && (w_sx < 11'(FB_W)) && (w_sy < 11'(FB_H));
  assign w_fb_addr = ADDR_W'(w_sy) * ADDR_W'(FB_W) + ADDR_W'(w_sx);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_adv) begin
          if (w_a_last) w_state_nxt = S_DRAIN;
          else          w_issue     = 1'b1;
        end
      end
      S_DRAIN: begin
        // Data stage empty and the final write (if any) leaving this cycle
        if (!r_d_vld && w_adv) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next raster position and the ROM address it maps to (column flipped when mirroring)
  always_comb begin
    w_row_nxt = r_a_row;
    w_col_nxt = r_a_col + COL_W'(1);
    if (w_accept) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (r_a_col == COL_W'(SPR_W-1)) begin
      w_row_nxt = r_a_row + ROW_W'(1);
      w_col_nxt = '0;
    end
    w_mir_nxt      = w_accept ? w_mirror_in : r_mirror;
    w_rom_col      = w_mir_nxt ? (COL_W'(SPR_W-1) - w_col_nxt) : w_col_nxt;
    w_rom_addr_nxt = ADDR_W'(w_row_nxt) * ADDR_W'(SPR_W) + ADDR_W'(w_rom_col);
  end

  // Pipeline, skid, output registers and busy/done
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_mirror   <= 1'b0;
      r_a_row    <= '0;
      r_a_col    <= '0;
      r_rom_addr <= '0;
      r_d_vld    <= 1'b0;
      r_d_row    <= '0;
      r_d_col    <= '0;
      r_skid_vld <= 1'b0;
      r_skid_pix <= '0;
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x      <= sprite_x;
        r_y      <= sprite_y;
        r_mirror <= w_mirror_in;
      end
      // Address counters hold on the last address, so rom_addr never passes N-1
      if (w_accept || w_issue) begin
        r_a_row    <= w_row_nxt;
        r_a_col    <= w_col_nxt;
        r_rom_addr <= w_rom_addr_nxt;
      end
      if (w_adv) begin
        r_d_vld    <= (r_state == S_RUN);
        r_d_row    <= r_a_row;
        r_d_col    <= r_a_col;
        r_skid_vld <= 1'b0;
        r_fb_we    <= r_d_vld && w_keep;
        if (r_d_vld && w_keep) begin
          r_fb_addr <= w_fb_addr;
          r_fb_data <= w_d_pix;
        end
      end else if (!r_skid_vld) begin
        // First stalled edge: the ROM is about to present the next address, keep this pixel
        r_skid_vld <= 1'b1;
        r_skid_pix <= rom_data;
      end
      if (w_accept)      r_busy <= 1'b1;
      else if (w_finish) r_busy <= 1'b0;
      r_done <= w_finish;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rom_addr = r_rom_addr;
  assign fb_addr  = r_fb_addr;
  assign fb_data  = r_fb_data;
  assign fb_we    = r_fb_we;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Bench for sprite_blit_engine: table of blit scenarios plus reset-mid-blit and mirror sequences.
// A raster model of the sprite fills a write queue at start; each accepted write is popped and compared.
// fb_ready is either held high or randomised; held outputs are checked on every stalled cycle.
module tb_sprite_blit_engine;

  localparam int N = 2400;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [9:0]  sprite_x, sprite_y;
  logic        mirror_in;
  logic        busy, done;
  logic [18:0] rom_addr;
  logic [4:0]  rom_data;
  logic [18:0] fb_addr;
  logic [4:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;

  sprite_blit_engine dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .sprite_x (sprite_x),
    .sprite_y (sprite_y),
`ifdef SPRITE_BLIT_MIRROR_EN
    .mirror   (mirror_in),
`endif
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .fb_ready (fb_ready)
  );

  always #5 Clk = ~Clk;

  // Registered-read ROM
  logic [4:0] rom [0:N-1];
  always @(posedge Clk) rom_data <= (rom_addr < 19'(N)) ? rom[rom_addr] : 5'd0;

  typedef struct packed {
    logic [18:0] a;
    logic [4:0]  d;
  } wr_t;
  wr_t sb[$];
  wr_t e;

  typedef struct {
    int x; int y; int mode; int rnd;
    int exp_wr; int exp_first; int exp_last; int exp_done; int exp_fcyc;
  } vec_t;
  vec_t vecs[6];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t_start = 0;
  int n_wr, done_cnt, done_cyc, first_we_cyc;
  logic [18:0] first_addr, last_addr, prev_addr;
  logic [4:0]  first_data, prev_data;
  logic        prev_stall = 1'b0;
  int rnd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // fb_ready driver
  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge Clk); #1;
      fb_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor and scoreboard
  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {7'd0, fb_we, fb_addr, fb_data}, {7'd0, 1'b1, prev_addr, prev_data});
      if (rom_addr > 19'(N-1)) check("rom_addr_range", 32'(rom_addr), N-1);
      if (fb_we && first_we_cyc < 0) first_we_cyc = cyc - t_start;
      if (fb_we && fb_ready) begin
        if (n_wr == 0) begin first_addr = fb_addr; first_data = fb_data; end
        last_addr = fb_addr;
        n_wr++;
        if (sb.size() == 0) check("sb_unexpected_write", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e.a));
          check("wr_data", 32'(fb_data), 32'(e.d));
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc - t_start; end
      prev_stall = fb_we && !fb_ready;
      prev_addr  = fb_addr;
      prev_data  = fb_data;
    end
  end

  task automatic fill_rom(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       rom[i] = 5'(i % 31 + 1);
        1:       rom[i] = (i == 41) ? 5'd7 : 5'd0;
        3:       rom[i] = 5'(i % 40);
        default: rom[i] = 5'd0;
      endcase
    end
  endtask

  // Expected writes in raster order for a sprite at (x,y)
  task automatic build_model(input int x, input int y, input int m);
    int sx, sy, rc;
    logic [4:0] d;
    sb.delete();
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 40; c++) begin
        sx = x + c;
        sy = y + r;
        rc = (m != 0) ? 39 - c : c;
        d  = rom[r*40 + rc];
        if (d != 5'd0 && sx < 640 && sy < 480) sb.push_back('{a: 19'(sy*640 + sx), d: d});
      end
    end
  endtask

  task automatic start_blit(input int x, input int y, input int m);
    n_wr = 0; done_cnt = 0; done_cyc = -1; first_we_cyc = -1;
    @(posedge Clk); #1;
    sprite_x  = 10'(x);
    sprite_y  = 10'(y);
    mirror_in = 1'(m);
    start     = 1'b1;
    @(posedge Clk); #1;
    t_start = cyc - 1;
    start   = 1'b0;
    check("busy_c1", 32'(busy), 1);
    check("rom_addr_c1", 32'(rom_addr), (m != 0) ? 39 : 0);
  endtask

  task automatic wait_done(input int spur);
    int k = 0;
    while (done_cnt == 0 && k < 20000) begin
      @(posedge Clk); #1;
      if (spur != 0) start = busy && ($urandom_range(0, 15) == 0);
      k++;
    end
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("busy_end", 32'(busy), 0);
    check("sb_left", sb.size(), 0);
  endtask

  task automatic run_case(input vec_t v);
    rnd = v.rnd;
    fill_rom(v.mode);
    build_model(v.x, v.y, 0);
    start_blit(v.x, v.y, 0);
    wait_done(v.rnd);
    check("write_count", n_wr, v.exp_wr);
    if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
    if (v.exp_fcyc >= 0) check("first_we_cycle", first_we_cyc, v.exp_fcyc);
    if (v.exp_wr > 0) begin
      check("first_addr", 32'(first_addr), v.exp_first);
      check("last_addr", 32'(last_addr), v.exp_last);
    end
  endtask

  initial begin
    vec_t vr;
    int k;
    //            x    y   mode rnd  writes first   last    done  fcyc
    vecs[0] = '{100,  50,  0,   0,   2400,  32100,  69899,  2403, 3};
    vecs[1] = '{100,  50,  1,   0,   1,     32741,  32741,  2403, 44};
    vecs[2] = '{620,  450, 0,   0,   600,   288620, 307199, 2403, 3};
    vecs[3] = '{5,    5,   2,   0,   0,     0,      0,      2403, -1};
    vecs[4] = '{700,  10,  0,   0,   0,     0,      0,      2403, -1};
    vecs[5] = '{10,   20,  0,   1,   2400,  12810,  50609,  -1,   -1};

    Reset_n = 1'b0; start = 1'b0; sprite_x = '0; sprite_y = '0; mirror_in = 1'b0;
    fill_rom(0);
    #23;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_fb_out", {8'd0, fb_addr, fb_data}, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_case(vecs[i]);

    // Reset in the middle of a blit, then a fresh blit from the origin
    rnd = 0;
    fill_rom(0);
    build_model(100, 50, 0);
    start_blit(100, 50, 0);
    k = 0;
    while (n_wr < 500 && k < 5000) begin @(negedge Clk); k++; end
    check("pre_reset_writes", n_wr, 500);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_fb_we", 32'(fb_we), 0);
    check("midrst_done", 32'(done), 0);
    sb.delete();
    repeat (3) @(negedge Clk);
    check("midrst_no_writes", 32'(fb_we), 0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    vr = '{0, 0, 0, 0, 2400, 0, 37799, 2403, 3};
    run_case(vr);

`ifdef SPRITE_BLIT_MIRROR_EN
    rnd = 0;
    fill_rom(3);
    build_model(200, 100, 1);
    start_blit(200, 100, 1);
    wait_done(0);
    check("mirror_first_addr", 32'(first_addr), 100*640 + 200);
    check("mirror_first_data", 32'(first_data), 39);
    check("mirror_done_cycle", done_cyc, 2403);
    mirror_in = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
- Reader/initiator for the per-sprite palette ROMs: walks a sprite ROM of fixed size in raster order and copies each pixel into the frame buffer at a given screen position.
- Skips transparent and off-screen pixels.
- Sits between the game-logic sprite scheduler (start/done handshake) and the frame-buffer write port (valid/ready).
- ROM has 1-cycle registered read latency.

Parameters:
- SPR_W, 40, sprite width in pixels.
- SPR_H, 60, sprite height in pixels (SPR_W*SPR_H = 2400 ROM entries).
- PIX_W, 5, palette index width.
- ADDR_W, 19, ROM and frame-buffer address width.
- FB_W, 640, frame-buffer width.
- FB_H, 480, frame-buffer height.
- TRANSPARENT, 0, palette index treated as transparent.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a blit; sampled only in IDLE.
- sprite_x  in  10  screen X of sprite top-left; latched on accepted start.
- sprite_y  in  10  screen Y of sprite top-left; latched on accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when the blit completes.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  PIX_W  ROM data; valid the cycle after rom_addr is presented.
- fb_addr  out  ADDR_W  frame-buffer write address.
- fb_data  out  PIX_W  frame-buffer write data.
- fb_we  out  1  write valid.
- fb_ready  in  1  frame buffer accepts the write when fb_we && fb_ready.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0, counters cleared, no pending pixel. Reset mid-blit abandons the blit; no further writes.
- States: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE: on start=1, latch sprite_x/sprite_y, clear row/col, go to RUN. Start is ignored in all other states.
- RUN:
  - Issue rom_addr = row*SPR_W + col.
  - Advance col; wrap to 0 and increment row at col = SPR_W-1.
  - After issuing the last address (row = SPR_H-1, col = SPR_W-1), go to DRAIN.
- Pipeline: address stage -> ROM data stage -> registered output stage.
  - Each returned pixel carries its screen coordinate: sx = sprite_x+col, sy = sprite_y+row, both computed 11 bits wide.
  - fb_addr = sy*FB_W + sx.
- Skip rules: the pixel produces no write when rom_data == TRANSPARENT, or sx >= FB_W, or sy >= FB_H. A skipped pixel still consumes its pipeline slot.
- Handshake:
  - While fb_we=1 and fb_ready=0, fb_addr/fb_data/fb_we hold stable and the address counters freeze.
  - A skid register holds the in-flight ROM pixel, so there is no loss or duplication.
  - fb_we may be 1 with fb_ready=0 indefinitely.
- DRAIN: wait until the pipeline is empty and the last write has been accepted. Then done=1 for one cycle, busy=0 in that same cycle, and return to IDLE.
- Latency with fb_ready held 1 and no skips (N = SPR_W*SPR_H):
  - start sampled at cycle 0.
  - rom_addr=0 at cycle 1.
  - First fb_we at cycle 3.
  - Last fb_we at cycle 2+N.
  - done at cycle 3+N.
  - Default parameters: done at cycle 2403.
- Zero writes (all pixels transparent or off-screen): done still pulses at cycle 3+N.
- rom_addr never exceeds N-1.

Optional Feature:
- Macro: SPRITE_BLIT_MIRROR_EN.
- Defined: adds input port mirror (1 bit), latched on accepted start. When latched 1, the ROM column read is SPR_W-1-col while the screen column stays sprite_x+col, i.e. a horizontally flipped draw. Timing is unchanged.
- Undefined: port absent; the ROM is always read unflipped.

Test Plan:
- Basic: ROM = address mod 31 + 1 (no zeros), start at x=100,y=50, fb_ready=1 -> 2400 writes; first write fb_addr = 50*640+100 = 32100, fb_data=1; last write fb_addr = 109*640+139 = 69899; done at cycle 2403.
- Transparency: ROM all 0 except entry 41 = 7 -> exactly one write, fb_addr=(y+1)*640+(x+1), fb_data=7; done at cycle 2403.
- Clipping: x=620, y=450 -> only cols 0..19 and rows 0..29 written (600 writes); no fb_addr with sx >= 640 or sy >= 480.
- Backpressure: fb_ready toggled by random 50% pattern -> 2400 writes in raster order with correct data; outputs stable while stalled; start pulses during busy ignored.
- Reset mid-blit: assert Reset_n=0 asynchronously after 500 writes -> busy, fb_we, done go 0 immediately; a new start after release begins at rom_addr=0.
- Mirror (macro defined): mirror=1, ROM row 0 = col index -> screen col 0 of row 0 receives data 39.
